// File: rtl/systolic_sequencer.sv
// systolic_sequencer: control FSM that runs a program of matrix-multiply jobs on the 4x4
// systolic array.
//
// Each instruction holds the job's inner dimension K. A K of 0, or the end of the program,
// halts the run. For each job the FSM:
//   - clears the PE accumulators,
//   - streams K columns from the A/B input memories,
//   - waits DRAIN_CYCLES for the array to drain,
//   - strobes the 16 results into output memory.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   ap_start         start pulse, accepted only in IDLE or DONE
//   ap_done          level, high in DONE until the next accepted start or reset
//   busy             high in every state except IDLE and DONE
//   instr_addr/rd    instruction memory address (= pc) and read strobe
//   instr_data       K for the current job, valid the cycle after instr_rd
//   sa_clear         one-cycle clear of the array accumulators
//   feed_en/col      input memory read enable and column address
//   out_wr_en/base   output memory write strobe and base address
// All outputs are registered and are decoded from the next state.
module systolic_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 7,
  parameter int unsigned PROG_DEPTH   = 8,
  localparam int unsigned PcW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ap_start,
  output logic           ap_done,
  output logic           busy,
  output logic [PcW-1:0] instr_addr,
  output logic           instr_rd,
  input  logic [3:0]     instr_data,
  output logic           sa_clear,
  output logic           feed_en,
  output logic [7:0]     feed_col,
  output logic           out_wr_en,
  output logic [6:0]     out_wr_base
);

  // cnt serves both the feed count (up to 15) and the drain count.
  localparam int unsigned CntW = (DRAIN_CYCLES > 16) ? $clog2(DRAIN_CYCLES) : 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StClear  = 3'd3;
  localparam logic [2:0] StFeed   = 3'd4;
  localparam logic [2:0] StDrain  = 3'd5;
  localparam logic [2:0] StWrite  = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  logic [2:0]      state, state_d;
  logic [PcW-1:0]  pc, pc_d;
  logic [7:0]      col_base, col_base_d;
  logic [6:0]      out_base, out_base_d;
  logic [CntW-1:0] cnt, cnt_d;
  logic [3:0]      k, k_d;

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    col_base_d = col_base;
    out_base_d = out_base;
    cnt_d      = cnt;
    k_d        = k;
    case (state)
      StIdle, StDone: begin
        if (ap_start) begin
          state_d    = StFetch;
          pc_d       = '0;
          col_base_d = '0;
          out_base_d = '0;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        k_d     = instr_data;
        state_d = (instr_data == 4'd0) ? StDone : StClear;
      end
      StClear: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt == CntW'(k) - CntW'(1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CntW'(1);
        end
      end
      StDrain: begin
        if (cnt == CntW'(DRAIN_CYCLES - 1)) begin
          state_d = StWrite;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CntW'(1);
        end
      end
      StWrite: begin
        col_base_d = col_base + 8'(k);
        out_base_d = out_base + 7'd16;
        pc_d       = pc + PcW'(1);
        // End-of-program test uses pc before it wraps.
        state_d    = (pc == PcW'(PROG_DEPTH - 1)) ? StDone : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      pc          <= '0;
      col_base    <= '0;
      out_base    <= '0;
      cnt         <= '0;
      k           <= '0;
      ap_done     <= 1'b0;
      busy        <= 1'b0;
      instr_addr  <= '0;
      instr_rd    <= 1'b0;
      sa_clear    <= 1'b0;
      feed_en     <= 1'b0;
      feed_col    <= '0;
      out_wr_en   <= 1'b0;
      out_wr_base <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      col_base  <= col_base_d;
      out_base  <= out_base_d;
      cnt       <= cnt_d;
      k         <= k_d;
      // Registered Moore outputs: decode the state being entered.
      ap_done   <= (state_d == StDone);
      busy      <= (state_d != StIdle) && (state_d != StDone);
      instr_rd  <= (state_d == StFetch);
      sa_clear  <= (state_d == StClear);
      feed_en   <= (state_d == StFeed);
      out_wr_en <= (state_d == StWrite);
      // Addresses hold their last value while their strobe is low.
      if (state_d == StFetch) instr_addr  <= pc_d;
      if (state_d == StFeed)  feed_col    <= col_base_d + 8'(cnt_d);
      if (state_d == StWrite) out_wr_base <= out_base_d;
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer: a cycle table for program [2,0], job-timeline
// checks for several programs, reset abort, start handshake and column/base wrap on a
// deeper-program instance.
module tb_systolic_sequencer;

  logic clk = 1'b0;
  logic rst, ap_start;
  always #5 clk = ~clk;

  // Default instance (PROG_DEPTH = 8).
  logic       ap_done, busy, instr_rd, sa_clear, feed_en, out_wr_en;
  logic [2:0] instr_addr;
  logic [3:0] instr_data;
  logic [7:0] feed_col;
  logic [6:0] out_wr_base;
  logic [3:0] imem [8];

  systolic_sequencer u_dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done), .busy(busy),
    .instr_addr(instr_addr), .instr_rd(instr_rd), .instr_data(instr_data),
    .sa_clear(sa_clear), .feed_en(feed_en), .feed_col(feed_col),
    .out_wr_en(out_wr_en), .out_wr_base(out_wr_base)
  );

  always @(posedge clk) begin
    if (rst) instr_data <= 4'd0;
    else if (instr_rd) instr_data <= imem[instr_addr];
  end

  // Deep-program instance, used to reach the column-255 wrap.
  logic       ap_done_w, busy_w, instr_rd_w, sa_clear_w, feed_en_w, out_wr_en_w;
  logic [4:0] instr_addr_w;
  logic [3:0] instr_data_w;
  logic [7:0] feed_col_w;
  logic [6:0] out_wr_base_w;
  logic [3:0] imem_w [32];

  systolic_sequencer #(.DRAIN_CYCLES(7), .PROG_DEPTH(32)) u_dut_w (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done_w), .busy(busy_w),
    .instr_addr(instr_addr_w), .instr_rd(instr_rd_w), .instr_data(instr_data_w),
    .sa_clear(sa_clear_w), .feed_en(feed_en_w), .feed_col(feed_col_w),
    .out_wr_en(out_wr_en_w), .out_wr_base(out_wr_base_w)
  );

  always @(posedge clk) begin
    if (rst) instr_data_w <= 4'd0;
    else if (instr_rd_w) instr_data_w <= imem_w[instr_addr_w];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // {done, busy, rd, clr, fen, wen, addr[3], col[8], base[7]}
  function automatic logic [23:0] pack_dut();
    return {ap_done, busy, instr_rd, sa_clear, feed_en, out_wr_en, instr_addr, feed_col,
            out_wr_base};
  endfunction

  typedef struct {
    int         cyc;
    logic       done, bsy, rd, clr, fen, wen;
    logic [2:0] addr;
    logic [7:0] col;
    logic [6:0] base;
  } row_t;

  // Trace of one run, cycle 1 = first cycle after the start edge.
  int fetch_q[$], clr_q[$], feed_c[$], feed_v[$], wr_c[$], wr_v[$];
  int done_cyc, busy_cnt;

  task automatic run(input int budget, input int pulse_at);
    fetch_q.delete(); clr_q.delete(); feed_c.delete(); feed_v.delete();
    wr_c.delete(); wr_v.delete();
    done_cyc = -1;
    busy_cnt = 0;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) chk("done_cleared_after_start", ap_done, 1'b0);
      if (instr_rd) fetch_q.push_back(c);
      if (sa_clear) clr_q.push_back(c);
      if (feed_en) begin feed_c.push_back(c); feed_v.push_back(feed_col); end
      if (out_wr_en) begin wr_c.push_back(c); wr_v.push_back(out_wr_base); end
      if (busy) busy_cnt++;
      ap_start = (c == pulse_at);
      if (ap_done) begin done_cyc = c; break; end
    end
    ap_start = 1'b0;
    if (done_cyc < 0) chk("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_q(input string name, input int act[$], input int exp[$]);
    chk({name, "_len"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // Job-level timeline: FETCH at f, CLEAR f+2, FEED f+3.., WRITE f+K+10, next FETCH f+K+11.
  task automatic check_prog(input string tag);
    int ef[$], ec[$], efc[$], efv[$], ewc[$], ewv[$];
    int f, col, ob, edone, kk;
    f = 1; col = 0; ob = 0; edone = -1;
    for (int p = 0; p < 8; p++) begin
      kk = int'(imem[p]);
      ef.push_back(f);
      if (kk == 0) begin edone = f + 2; break; end
      ec.push_back(f + 2);
      for (int i = 0; i < kk; i++) begin
        efc.push_back(f + 3 + i);
        efv.push_back((col + i) % 256);
      end
      ewc.push_back(f + kk + 10);
      ewv.push_back(ob);
      col = (col + kk) % 256;
      ob = (ob + 16) % 128;
      if (p == 7) begin edone = f + kk + 11; break; end
      f += kk + 11;
    end
    chk({tag, "_done_cyc"}, done_cyc, edone);
    chk({tag, "_busy_cycles"}, busy_cnt, edone - 1);
    cmp_q({tag, "_fetch"}, fetch_q, ef);
    cmp_q({tag, "_clear"}, clr_q, ec);
    cmp_q({tag, "_feed_cyc"}, feed_c, efc);
    cmp_q({tag, "_feed_col"}, feed_v, efv);
    cmp_q({tag, "_wr_cyc"}, wr_c, ewc);
    cmp_q({tag, "_wr_base"}, wr_v, ewv);
  endtask

  initial begin
    row_t tbl[12];
    int   idx, wen_seen;
    int   wf[$], wb[$];

    tbl[0]  = '{1,  0, 1, 1, 0, 0, 0, 3'd0, 8'd0, 7'd0};
    tbl[1]  = '{2,  0, 1, 0, 0, 0, 0, 3'd0, 8'd0, 7'd0};
    tbl[2]  = '{3,  0, 1, 0, 1, 0, 0, 3'd0, 8'd0, 7'd0};
    tbl[3]  = '{4,  0, 1, 0, 0, 1, 0, 3'd0, 8'd0, 7'd0};
    tbl[4]  = '{5,  0, 1, 0, 0, 1, 0, 3'd0, 8'd1, 7'd0};
    tbl[5]  = '{6,  0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 7'd0};
    tbl[6]  = '{12, 0, 1, 0, 0, 0, 0, 3'd0, 8'd1, 7'd0};
    tbl[7]  = '{13, 0, 1, 0, 0, 0, 1, 3'd0, 8'd1, 7'd0};
    tbl[8]  = '{14, 0, 1, 1, 0, 0, 0, 3'd1, 8'd1, 7'd0};
    tbl[9]  = '{15, 0, 1, 0, 0, 0, 0, 3'd1, 8'd1, 7'd0};
    tbl[10] = '{16, 1, 0, 0, 0, 0, 0, 3'd1, 8'd1, 7'd0};
    tbl[11] = '{17, 1, 0, 0, 0, 0, 0, 3'd1, 8'd1, 7'd0};

    for (int i = 0; i < 8; i++) imem[i] = 4'd0;
    for (int i = 0; i < 32; i++) imem_w[i] = 4'd0;

    // Reset, with ap_start on a reset edge: reset wins.
    rst = 1'b1;
    ap_start = 1'b0;
    repeat (3) @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    chk("reset_outputs", pack_dut(), 24'd0);
    chk("reset_beats_start_busy", busy, 1'b0);
    ap_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", pack_dut(), 24'd0);

    // Program [2,0]: cycle-by-cycle table.
    imem[0] = 4'd2;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    idx = 0;
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) @(negedge clk);
      if (idx < 12 && tbl[idx].cyc == c) begin
        chk($sformatf("tbl_cycle_%0d", c), pack_dut(),
            {tbl[idx].done, tbl[idx].bsy, tbl[idx].rd, tbl[idx].clr, tbl[idx].fen,
             tbl[idx].wen, tbl[idx].addr, tbl[idx].col, tbl[idx].base});
        idx++;
      end
    end

    // Program [4,3,0], restarted from DONE, with an ignored ap_start pulse mid-FEED.
    imem[0] = 4'd4; imem[1] = 4'd3; imem[2] = 4'd0;
    run(200, 6);
    check_prog("prog_4_3");

    // Eight K=1 jobs: end-of-program halt.
    for (int i = 0; i < 8; i++) imem[i] = 4'd1;
    run(300, -1);
    check_prog("k1x8");
    chk("k1x8_done_at_97", done_cyc, 97);
    chk("k1x8_last_base", (wr_v.size() == 8) ? wr_v[7] : -1, 112);

    // Reset during the 2nd FEED cycle of K=5.
    for (int i = 0; i < 8; i++) imem[i] = 4'd0;
    imem[0] = 4'd5;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    repeat (4) @(negedge clk);   // cycle 5
    chk("abort_in_feed", {feed_en, feed_col}, {1'b1, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs_zero", pack_dut(), 24'd0);
    rst = 1'b0;
    wen_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_wr_en || busy) wen_seen++;
    end
    chk("abort_stays_idle", wen_seen, 0);
    run(200, -1);
    check_prog("after_abort");

    // Wrap on the deep instance: 16x15 + 14 brings col_base to 254, then K=4.
    for (int i = 0; i < 16; i++) imem_w[i] = 4'd15;
    imem_w[16] = 4'd14;
    imem_w[17] = 4'd4;
    imem_w[18] = 4'd0;
    @(negedge clk);
    ap_start = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    idx = -1;
    for (int c = 1; c <= 700; c++) begin
      if (c > 1) @(negedge clk);
      if (feed_en_w) wf.push_back(feed_col_w);
      if (out_wr_en_w) wb.push_back(out_wr_base_w);
      if (ap_done_w) begin idx = c; break; end
    end
    chk("wrap_done_seen", (idx > 0), 1'b1);
    chk("wrap_feed_count", wf.size(), 258);
    chk("wrap_write_count", wb.size(), 18);
    if (wf.size() == 258) begin
      chk("wrap_col0", wf[254], 254);
      chk("wrap_col1", wf[255], 255);
      chk("wrap_col2", wf[256], 0);
      chk("wrap_col3", wf[257], 1);
    end
    if (wb.size() == 18) begin
      chk("wrap_base_8", wb[8], 0);
      chk("wrap_base_17", wb[17], 16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
